// File: rtl/apb5_req_master.sv
// APB5 request master: turns single valid/ready commands into a WAKE -> SETUP -> ACCESS
// sequence and returns the completer's response on a valid/ready channel.
module apb5_req_master #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int USER_REQ_WIDTH  = 32,
    parameter int USER_DATA_WIDTH = 32,
    parameter int USER_RESP_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr,
    input  logic [2:0]                 cmd_prot,
    input  logic [DATA_WIDTH-1:0]      cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]    cmd_strb,
    input  logic [USER_REQ_WIDTH-1:0]  cmd_auser,
    input  logic [USER_DATA_WIDTH-1:0] cmd_wuser,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic                       rsp_timeout,
    output logic [USER_DATA_WIDTH-1:0] rsp_ruser,
    output logic [USER_RESP_WIDTH-1:0] rsp_buser,
    output logic [ADDR_WIDTH-1:0]      paddr,
    output logic [2:0]                 pprot,
    output logic                       pselx,
    output logic                       penable,
    output logic                       pwrite,
    output logic [DATA_WIDTH-1:0]      pwdata,
    output logic [DATA_WIDTH/8-1:0]    pstrb,
    output logic                       pwakeup,
    output logic [USER_REQ_WIDTH-1:0]  pauser,
    output logic [USER_DATA_WIDTH-1:0] pwuser,
    input  logic                       pready,
    input  logic [DATA_WIDTH-1:0]      prdata,
    input  logic                       pslverr,
    input  logic [USER_DATA_WIDTH-1:0] pruser,
    input  logic [USER_RESP_WIDTH-1:0] pbuser
);

    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAKE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_done;
    logic             w_abort;
    logic             w_limit;

    // Abort on the cycle whose stall would bring the count up to the limit.
    assign w_limit = TO_EN && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = S_WAKE;
                end
            end
            S_WAKE:  w_state_next = S_SETUP;
            S_SETUP: w_state_next = S_ACCESS;
            S_ACCESS: begin
                if (pready) begin
                    w_done       = 1'b1;
                    w_state_next = S_RESP;
                end else if (w_limit) begin
                    w_abort      = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_ruser   <= '0;
            rsp_buser   <= '0;
            paddr       <= '0;
            pprot       <= '0;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
            pwakeup     <= 1'b0;
            pauser      <= '0;
            pwuser      <= '0;
            r_cnt       <= '0;
        end else begin
            cmd_ready <= (w_state_next == S_IDLE);
            // Request fields are frozen at accept and held until the next accept.
            if (w_accept) begin
                pwakeup <= 1'b1;
                paddr   <= cmd_addr;
                pprot   <= cmd_prot;
                pwrite  <= cmd_write;
                pauser  <= cmd_auser;
                pwdata  <= cmd_write ? cmd_wdata : '0;
                pstrb   <= cmd_write ? cmd_strb  : '0;
                pwuser  <= cmd_write ? cmd_wuser : '0;
            end
            if (r_state == S_WAKE) begin
                pselx <= 1'b1;
            end
            if (r_state == S_SETUP) begin
                penable <= 1'b1;
                r_cnt   <= '0;
            end
            if (TO_EN && (r_state == S_ACCESS) && !pready && !w_limit) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done || w_abort) begin
                pselx       <= 1'b0;
                penable     <= 1'b0;
                pwakeup     <= 1'b0;
                rsp_valid   <= 1'b1;
                rsp_err     <= w_abort ? 1'b1 : pslverr;
                rsp_timeout <= w_abort;
                rsp_rdata   <= (w_done && !pwrite) ? prdata : '0;
                rsp_ruser   <= (w_done && !pwrite) ? pruser : '0;
                rsp_buser   <= w_done ? pbuser : '0;
            end
            if ((r_state == S_RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb5_req_master.sv
// Bench for apb5_req_master: directed vector table, hand sequences for reset and chaining,
// and randomized transfers checked against a transaction-level model.
module tb_apb5_req_master;

    localparam int TO = 4;

    logic        pclk;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_prot;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [31:0] cmd_auser;
    logic [31:0] cmd_wuser;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] rsp_ruser;
    logic [31:0] rsp_buser;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pwakeup;
    logic [31:0] pauser;
    logic [31:0] pwuser;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [31:0] pruser;
    logic [31:0] pbuser;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int acc_cyc  = 0;

    apb5_req_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_REQ_WIDTH(32),
        .USER_DATA_WIDTH(32), .USER_RESP_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_prot(cmd_prot), .cmd_wdata(cmd_wdata),
        .cmd_strb(cmd_strb), .cmd_auser(cmd_auser), .cmd_wuser(cmd_wuser),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .rsp_ruser(rsp_ruser),
        .rsp_buser(rsp_buser),
        .paddr(paddr), .pprot(pprot), .pselx(pselx), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pwakeup(pwakeup),
        .pauser(pauser), .pwuser(pwuser),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .pruser(pruser), .pbuser(pbuser)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] auser;
        logic [31:0] wuser;
        int          waits;
        logic [31:0] prdata;
        logic [31:0] pruser;
        bit          pslverr;
        logic [31:0] pbuser;
        int          hold;
        int          exp_acc;
        bit          exp_err;
        bit          exp_to;
        logic [31:0] exp_rdata;
        logic [31:0] exp_ruser;
        logic [31:0] exp_buser;
    } vec_t;

    function automatic vec_t mkv(bit w, logic [31:0] a, logic [31:0] wd, logic [3:0] st,
                                 int waits, logic [31:0] rd, logic [31:0] ru, bit se,
                                 logic [31:0] bu, int hold, int eacc, bit eerr, bit eto,
                                 logic [31:0] erd, logic [31:0] eru, logic [31:0] ebu);
        vec_t v;
        v.write = w;    v.addr = a;    v.prot = a[6:4];  v.wdata = wd;  v.strb = st;
        v.auser = a ^ 32'h5A00_0000;   v.wuser = wd ^ 32'h0F0F_0F0F;
        v.waits = waits; v.prdata = rd; v.pruser = ru;   v.pslverr = se; v.pbuser = bu;
        v.hold = hold;  v.exp_acc = eacc; v.exp_err = eerr; v.exp_to = eto;
        v.exp_rdata = erd; v.exp_ruser = eru; v.exp_buser = ebu;
        return v;
    endfunction

    // Transaction-level expectation: a completer that answers after `waits` stalls,
    // cut short by the timeout limit.
    function automatic vec_t model(input vec_t t);
        vec_t r;
        bit   to;
        r  = t;
        to = (TO > 0) && (t.waits >= TO);
        r.exp_acc   = to ? TO : t.waits + 1;
        r.exp_to    = to;
        r.exp_err   = to ? 1'b1 : t.pslverr;
        r.exp_rdata = (to || t.write) ? 32'h0 : t.prdata;
        r.exp_ruser = (to || t.write) ? 32'h0 : t.pruser;
        r.exp_buser = to ? 32'h0 : t.pbuser;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input bit sel, input bit en, input bit wak,
                           input bit crdy, input bit rv);
        chk({tag, ".pselx"},     64'(pselx),     64'(sel));
        chk({tag, ".penable"},   64'(penable),   64'(en));
        chk({tag, ".pwakeup"},   64'(pwakeup),   64'(wak));
        chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'(crdy));
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(rv));
    endtask

    task automatic chk_req(input string tag, input vec_t t);
        chk({tag, ".paddr"},  64'(paddr),  64'(t.addr));
        chk({tag, ".pprot"},  64'(pprot),  64'(t.prot));
        chk({tag, ".pwrite"}, 64'(pwrite), 64'(t.write));
        chk({tag, ".pauser"}, 64'(pauser), 64'(t.auser));
        chk({tag, ".pstrb"},  64'(pstrb),  64'(t.write ? t.strb  : 4'h0));
        chk({tag, ".pwdata"}, 64'(pwdata), 64'(t.write ? t.wdata : 32'h0));
        chk({tag, ".pwuser"}, 64'(pwuser), 64'(t.write ? t.wuser : 32'h0));
    endtask

    task automatic chk_rsp(input string tag, input vec_t t);
        chk({tag, ".rsp_rdata"},   64'(rsp_rdata),   64'(t.exp_rdata));
        chk({tag, ".rsp_err"},     64'(rsp_err),     64'(t.exp_err));
        chk({tag, ".rsp_timeout"}, 64'(rsp_timeout), 64'(t.exp_to));
        chk({tag, ".rsp_ruser"},   64'(rsp_ruser),   64'(t.exp_ruser));
        chk({tag, ".rsp_buser"},   64'(rsp_buser),   64'(t.exp_buser));
    endtask

    task automatic drive_cmd(input vec_t t);
        cmd_write = t.write; cmd_addr = t.addr; cmd_prot = t.prot; cmd_wdata = t.wdata;
        cmd_strb = t.strb;   cmd_auser = t.auser; cmd_wuser = t.wuser; cmd_valid = 1'b1;
    endtask

    task automatic drive_junk();
        prdata  = $urandom();
        pruser  = $urandom();
        pbuser  = $urandom();
        pslverr = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        preset = 1'b1; cmd_valid = 1'b0; pready = 1'b0; rsp_ready = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
    endtask

    // Entered and left on a negedge; cmd_ready is registered so its negedge value
    // is what the next posedge samples.
    task automatic run_txn(input vec_t t, input bit chain, input vec_t nxt, input string tag);
        int n;
        drive_cmd(t);
        rsp_ready = (t.hold == 0);
        pready    = 1'b0;
        drive_junk();
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge pclk);
            n++;
        end
        if (!cmd_ready) begin
            chk({tag, ".accept_wait"}, 64'(cmd_ready), 64'd1);
            do_reset();
            return;
        end
        @(negedge pclk);
        acc_cyc = cyc_cnt;
        chk_ctl({tag, ".wake"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_req({tag, ".wake"}, t);
        if (chain) drive_cmd(nxt);
        else cmd_valid = 1'b0;
        @(negedge pclk);
        chk_ctl({tag, ".setup"}, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_req({tag, ".setup"}, t);
        for (int j = 0; j < t.exp_acc; j++) begin
            @(negedge pclk);
            chk_ctl($sformatf("%s.access%0d", tag, j), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            chk_req($sformatf("%s.access%0d", tag, j), t);
            pready = (j == t.waits);
            if (pready) begin
                prdata = t.prdata; pruser = t.pruser; pbuser = t.pbuser; pslverr = t.pslverr;
            end else begin
                drive_junk();
            end
        end
        @(negedge pclk);
        pready = 1'b0;
        drive_junk();
        chk_ctl({tag, ".resp"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_rsp({tag, ".resp"}, t);
        chk_req({tag, ".resp"}, t);
        for (int h = 0; h < t.hold; h++) begin
            @(negedge pclk);
            chk_ctl($sformatf("%s.hold%0d", tag, h), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk_rsp($sformatf("%s.hold%0d", tag, h), t);
        end
        rsp_ready = 1'b1;
        @(negedge pclk);
        chk({tag, ".done.rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".done.cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    vec_t vecs[8];

    initial begin
        vec_t a;
        vec_t b;
        int   t0;

        vecs[0] = mkv(1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 0, 32'h1111_1111, 32'h22, 1'b0,
                      32'h0, 0, 1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        vecs[1] = mkv(1'b0, 32'h20, 32'h3333_3333, 4'hF, 3, 32'hDEAD_BEEF, 32'h7, 1'b0,
                      32'h0, 0, 4, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h7, 32'h0);
        vecs[2] = mkv(1'b0, 32'h24, 32'h0, 4'h3, 0, 32'h1234_5678, 32'h5, 1'b1,
                      32'h3, 1, 1, 1'b1, 1'b0, 32'h1234_5678, 32'h5, 32'h3);
        vecs[3] = mkv(1'b0, 32'h30, 32'h0, 4'hF, 10, 32'h5555_AAAA, 32'h9, 1'b0,
                      32'h4, 0, 4, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
        vecs[4] = mkv(1'b0, 32'h34, 32'h0, 4'hF, 3, 32'hCAFE_F00D, 32'h1, 1'b0,
                      32'h2, 2, 4, 1'b0, 1'b0, 32'hCAFE_F00D, 32'h1, 32'h2);
        vecs[5] = mkv(1'b1, 32'h38, 32'h0102_0304, 4'h5, 1, 32'hFFFF_0000, 32'h6, 1'b0,
                      32'h9, 6, 2, 1'b0, 1'b0, 32'h0, 32'h0, 32'h9);
        vecs[6] = mkv(1'b1, 32'h3C, 32'hFEED_0001, 4'hC, 4, 32'h7777_7777, 32'h8, 1'b1,
                      32'hB, 0, 4, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
        vecs[7] = mkv(1'b1, 32'h40, 32'h0, 4'h1, 2, 32'h0, 32'h0, 1'b1,
                      32'hE, 0, 3, 1'b1, 1'b0, 32'h0, 32'h0, 32'hE);

        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_prot = '0;
        cmd_wdata = '0; cmd_strb = '0; cmd_auser = '0; cmd_wuser = '0; rsp_ready = 1'b0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0; pruser = '0; pbuser = '0;
        repeat (3) @(negedge pclk);
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.paddr",     64'(paddr),     64'd0);
        chk("reset.pwdata",    64'(pwdata),    64'd0);
        chk("reset.pstrb",     64'(pstrb),     64'd0);
        chk("reset.rsp_err",   64'(rsp_err),   64'd0);
        chk("reset.rsp_rdata", 64'(rsp_rdata), 64'd0);
        preset = 1'b0;
        @(negedge pclk);
        chk("release.cmd_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], 1'b0, vecs[i], $sformatf("vec%0d", i));
        end

        // Zero-wait back-to-back commands: accept edges five cycles apart.
        a = mkv(1'b1, 32'h100, 32'h0000_BEEF, 4'hF, 0, 32'h0, 32'h0, 1'b0,
                32'h0, 0, 1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        b = mkv(1'b0, 32'h104, 32'h0, 4'hF, 0, 32'h0BAD_F00D, 32'h4, 1'b0,
                32'h1, 0, 1, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h4, 32'h1);
        run_txn(a, 1'b1, b, "b2b0");
        t0 = acc_cyc;
        run_txn(b, 1'b0, b, "b2b1");
        chk("b2b.spacing", 64'(acc_cyc - t0), 64'd5);

        // Second command queued while the first sits in RESP with rsp_ready low.
        run_txn(vecs[5], 1'b1, vecs[1], "queue0");
        run_txn(vecs[1], 1'b0, vecs[1], "queue1");

        // Reset in the middle of ACCESS discards the transfer.
        a = mkv(1'b0, 32'h50, 32'h0, 4'hF, 10, 32'h0, 32'h0, 1'b0,
                32'h0, 0, 4, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
        drive_cmd(a);
        rsp_ready = 1'b1;
        pready    = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk_ctl("mrst.access", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        preset = 1'b1;
        @(negedge pclk);
        chk_ctl("mrst.reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mrst.paddr", 64'(paddr), 64'd0);
        preset = 1'b0;
        @(negedge pclk);
        chk_ctl("mrst.release", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge pclk);
        chk("mrst.idle.rsp_valid", 64'(rsp_valid), 64'd0);
        b = mkv(1'b0, 32'h54, 32'h0, 4'hF, 1, 32'h600D_CAFE, 32'h3, 1'b0,
                32'h1, 0, 2, 1'b0, 1'b0, 32'h600D_CAFE, 32'h3, 32'h1);
        run_txn(b, 1'b0, b, "mrst.fresh");

        for (int i = 0; i < 40; i++) begin
            vec_t r;
            r.write   = 1'($urandom_range(0, 1));
            r.addr    = $urandom();
            r.prot    = 3'($urandom());
            r.wdata   = $urandom();
            r.strb    = 4'($urandom());
            r.auser   = $urandom();
            r.wuser   = $urandom();
            r.waits   = int'($urandom_range(0, 6));
            r.prdata  = $urandom();
            r.pruser  = $urandom();
            r.pslverr = 1'($urandom_range(0, 1));
            r.pbuser  = $urandom();
            r.hold    = int'($urandom_range(0, 3));
            r = model(r);
            run_txn(r, 1'b0, r, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
